// File: rtl/uart_tx_piso.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_piso
//  Description : Parallel-in, serial-out UART transmitter. Accepts one word
//                over a valid/ready handshake and sends it as
//                start bit, data bits (LSB first), optional parity bit,
//                then one or two stop bits. Each bit lasts CLKS_PER_BIT clocks.
//  Ports       : tx_clk     - transmit clock, rising edge
//                rst        - synchronous active-high reset
//                tx_data    - word to send, sampled only at acceptance
//                tx_valid   - tx_data is valid
//                tx_ready   - block can accept a word (state is IDLE)
//                serial_out - registered serial line, idles high
//                busy       - frame in progress (state is not IDLE)
//                tx_done    - one-cycle pulse in the last clock of the frame
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_piso #(
  // Word width; kept equal to the shared UART parameter set (8).
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  tx_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  tx_done
);

  // A one-clock bit still needs a one-bit counter.
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Bit counter is shared by the data bits and the stop bits.
  localparam int BIT_W  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_INV   = (PARITY_ODD != 0);
  localparam logic              HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [BAUD_W-1:0]     baud_cnt, baud_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  par_bit, par_nxt;
  logic                  serial_nxt;
  logic                  done_nxt;
  logic                  baud_tick;

  assign baud_tick = (baud_cnt == BAUD_LAST);

  // Next-state logic. Outputs are derived from the *next* state so that the
  // registered serial_out and tx_done line up with the state they describe.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    par_nxt   = par_bit;

    if (state != S_IDLE) begin
      baud_nxt = baud_tick ? '0 : baud_cnt + 1'b1;
    end

    unique case (state)
      S_IDLE: begin
        if (tx_valid) begin
          state_nxt = S_START;
          baud_nxt  = '0;
          bit_nxt   = '0;
          shreg_nxt = tx_data;
          // Parity is fixed at acceptance; the shift register is consumed later.
          par_nxt   = (^tx_data) ^ PAR_INV;
        end
      end
      S_START: begin
        if (baud_tick) begin
          state_nxt = S_DATA;
          bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          shreg_nxt = shreg >> 1;
          if (bit_cnt == DATA_LAST) begin
            state_nxt = HAS_PAR ? S_PARITY : S_STOP;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          state_nxt = S_STOP;
          bit_nxt   = '0;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (bit_cnt == STOP_LAST) begin
            state_nxt = S_IDLE;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    unique case (state_nxt)
      S_START:  serial_nxt = 1'b0;
      S_DATA:   serial_nxt = shreg_nxt[0];
      S_PARITY: serial_nxt = par_nxt;
      default:  serial_nxt = 1'b1;
    endcase

    // High for the final clock of the final stop bit.
    done_nxt = (state_nxt == S_STOP) && (baud_nxt == BAUD_LAST) &&
               (bit_nxt == STOP_LAST);
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      serial_out <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= shreg_nxt;
      par_bit    <= par_nxt;
      serial_out <= serial_nxt;
      tx_done    <= done_nxt;
    end
  end

  assign tx_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_piso.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_piso
//  Description : Directed self-checking bench for uart_tx_piso. Four instances
//                cover the default framing, even parity with one stop bit,
//                odd parity with two stop bits, and one clock per bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_piso;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       vld [4];
  logic       so  [4];
  logic       rdy [4];
  logic       bsy [4];
  logic       dn  [4];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  uart_tx_piso #(.CLKS_PER_BIT(16)) dut0 (
    .tx_clk(clk), .rst(rst), .tx_data(data), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .serial_out(so[0]), .busy(bsy[0]), .tx_done(dn[0]));

  uart_tx_piso #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .tx_clk(clk), .rst(rst), .tx_data(data), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .serial_out(so[1]), .busy(bsy[1]), .tx_done(dn[1]));

  uart_tx_piso #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .tx_clk(clk), .rst(rst), .tx_data(data), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .serial_out(so[2]), .busy(bsy[2]), .tx_done(dn[2]));

  uart_tx_piso #(.CLKS_PER_BIT(1)) dut3 (
    .tx_clk(clk), .rst(rst), .tx_data(data), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .serial_out(so[3]), .busy(bsy[3]), .tx_done(dn[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for ready, present the word, and let one edge accept it.
  // Returns #1 after the acceptance edge, i.e. in cycle 1 of the frame.
  task automatic accept(input int d, input logic [7:0] w, input bit hold);
    int n = 0;
    while (rdy[d] !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) check($sformatf("ready_timeout_d%0d", d), 32'd0, 32'd1);
    data   = w;
    vld[d] = 1'b1;
    @(posedge clk); #1;
    if (!hold) vld[d] = 1'b0;
  endtask

  // Walk cycles 1..flen of a frame, then check cycle flen+1.
  task automatic check_frame(input int d, input logic [7:0] w, input int cpb,
                             input int pe, input bit par_bit, input int sb,
                             input int flen, input bit disturb);
    logic bitv [12];
    int   nb;
    int   bi;
    int   hold_err = 0;
    int   busy_err = 0;
    int   ndone    = 0;
    int   done_at  = 0;
    for (int i = 0; i < 12; i++) bitv[i] = 1'b1;
    bitv[0] = 1'b0;
    for (int i = 0; i < 8; i++) bitv[1 + i] = w[i];
    nb = 9;
    if (pe != 0) begin
      bitv[nb] = par_bit;
      nb++;
    end
    nb = nb + sb;
    for (int k = 1; k <= flen; k++) begin
      bi = (k - 1) / cpb;
      if (bi > 11) bi = 11;
      if (so[d] !== bitv[bi]) hold_err++;
      if ((k - 1) % cpb == cpb / 2)
        check($sformatf("d%0d_w%0h_bit%0d", d, w, bi), {31'd0, so[d]}, {31'd0, bitv[bi]});
      if (bsy[d] !== 1'b1) busy_err++;
      if (dn[d] === 1'b1) begin
        ndone++;
        done_at = k;
      end
      if (disturb && k == 40) begin
        data   = 8'h3C;
        vld[d] = 1'b1;
      end
      if (disturb && k == 50) vld[d] = 1'b0;
      @(posedge clk); #1;
    end
    check($sformatf("d%0d_bitcount", d), nb, (flen / cpb));
    check($sformatf("d%0d_hold_err", d), hold_err, 0);
    check($sformatf("d%0d_busy_err", d), busy_err, 0);
    check($sformatf("d%0d_done_count", d), ndone, 1);
    check($sformatf("d%0d_done_cycle", d), done_at, flen);
    check($sformatf("d%0d_ready_after", d), {31'd0, rdy[d]}, 32'd1);
    check($sformatf("d%0d_line_after", d), {31'd0, so[d]}, 32'd1);
    check($sformatf("d%0d_done_after", d), {31'd0, dn[d]}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    int dcount;

    // Reset with valid asserted: nothing may be accepted.
    rst  = 1'b1;
    data = 8'hA5;
    for (int i = 0; i < 4; i++) vld[i] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) vld[i] = 1'b0;
    @(posedge clk); #1;
    check("rst_serial", {31'd0, so[0]}, 32'd1);
    check("rst_ready",  {31'd0, rdy[0]}, 32'd1);
    check("rst_done",   {31'd0, dn[0]}, 32'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("rst_busy_d%0d", i), {31'd0, bsy[i]}, 32'd0);

    // Basic 0xA5 frame, 16 clocks per bit.
    accept(0, 8'hA5, 1'b0);
    check_frame(0, 8'hA5, 16, 0, 1'b0, 1, 160, 1'b0);

    // One clock per bit.
    accept(3, 8'hA5, 1'b0);
    check_frame(3, 8'hA5, 1, 0, 1'b0, 1, 10, 1'b0);

    // Parity on 0x07 (three ones): even -> 1, odd -> 0.
    accept(1, 8'h07, 1'b0);
    check_frame(1, 8'h07, 16, 1, 1'b1, 1, 176, 1'b0);
    accept(2, 8'h07, 1'b0);
    check_frame(2, 8'h07, 16, 1, 1'b0, 2, 192, 1'b0);

    // Back-to-back with valid held: one idle cycle, then the next start bit.
    accept(0, 8'h00, 1'b1);
    check_frame(0, 8'h00, 16, 0, 1'b0, 1, 160, 1'b0);
    data = 8'hFF;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    check_frame(0, 8'hFF, 16, 0, 1'b0, 1, 160, 1'b0);

    // Input isolation: new data and a valid pulse mid-frame are ignored.
    accept(0, 8'h5A, 1'b0);
    check_frame(0, 8'h5A, 16, 0, 1'b0, 1, 160, 1'b1);
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      if (bsy[0] !== 1'b0 || so[0] !== 1'b1) extra++;
      @(posedge clk); #1;
    end
    check("no_extra_frame", extra, 0);

    // Reset during data bit 3 (frame cycles 65..80).
    accept(0, 8'hA5, 1'b0);
    repeat (68) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_serial", {31'd0, so[0]}, 32'd1);
    check("midrst_busy",   {31'd0, bsy[0]}, 32'd0);
    rst    = 1'b0;
    dcount = 0;
    for (int k = 0; k < 200; k++) begin
      if (dn[0] === 1'b1) dcount++;
      @(posedge clk); #1;
    end
    check("midrst_no_done", dcount, 0);
    accept(0, 8'h81, 1'b0);
    check_frame(0, 8'h81, 16, 0, 1'b0, 1, 160, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_piso.md
# uart_tx_piso

Parallel-in, serial-out UART transmitter. It accepts one `DATA_WIDTH`-bit word through a valid/ready handshake and frames it as: start bit, data bits LSB first, optional parity bit, then one or two stop bits. Each bit is held for `CLKS_PER_BIT` clocks. It is the transmit-side counterpart of the receive-path serial-to-parallel block and sits between the host-side byte source and the TX pin.

## Interface
- `DATA_WIDTH`, 8: word width in bits; takes its value from `uart_params.vh`.
- `CLKS_PER_BIT`, 16: clocks per serial bit; must be at least 1.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `tx_clk` input 1: transmit clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `tx_data` input `DATA_WIDTH`: word to send; sampled only at acceptance.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: block can accept a word; equals (state == IDLE).
- `serial_out` output 1: registered serial line; idles high.
- `busy` output 1: frame in progress; equals (state != IDLE).
- `tx_done` output 1: registered one-cycle pulse in the last clock of the final stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- **Acceptance:** occurs at a rising edge where `tx_valid` & `tx_ready` & !`rst`.
  - `tx_data` is copied into an internal shift register.
  - Bit counter and baud counter are cleared; state goes to START.
- **Isolation from inputs:** after acceptance, `tx_data` and `tx_valid` have no effect until the block returns to IDLE. `tx_valid` asserted while busy is not accepted.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1. Each state holds for exactly `CLKS_PER_BIT` clocks and advances when the counter reaches `CLKS_PER_BIT`-1.
- **START:** `serial_out` = 0.
- **DATA:** `serial_out` = shift register bit 0. The register shifts right at each bit boundary. A bit counter runs 0..`DATA_WIDTH`-1. After the last data bit, go to PARITY if `PARITY_EN`, else STOP.
- **PARITY:** `serial_out` = XOR of the latched word, inverted when `PARITY_ODD`=1. The parity value is computed from the word as latched at acceptance.
- **STOP:** `serial_out` = 1 for `STOP_BITS`×`CLKS_PER_BIT` clocks. `tx_done` = 1 during the final clock. Then go to IDLE.
- **IDLE:** `serial_out` = 1.
- **Reset:** state = IDLE, `serial_out` = 1, `tx_done` = 0, all counters and the shift register cleared.
  - Consequently `tx_ready` = 1 and `busy` = 0 in the first cycle after reset.
- **Reset mid-frame:** the frame is abandoned. `serial_out` is 1 from the next cycle, and no `tx_done` pulse is produced for that frame.

## Timing
- Let F = `CLKS_PER_BIT`×(1 + `DATA_WIDTH` + `PARITY_EN` + `STOP_BITS`).
- The acceptance edge is cycle 0. The start bit appears on `serial_out` in cycles 1..`CLKS_PER_BIT`.
- The frame occupies cycles 1..F. `tx_done` is high in cycle F.
- IDLE with `tx_ready` = 1 in cycle F+1. The earliest next start bit is in cycle F+2, so consecutive frames are separated by exactly one idle-high cycle.
- `serial_out` changes only at bit boundaries; it is glitch-free because it is registered.
- `CLKS_PER_BIT` = 1 is legal: one clock per bit.

## Test plan
- **Reset check:** assert `rst` for 3 cycles with `tx_valid` = 1. Required: no acceptance; `serial_out` = 1, `tx_ready` = 1, `busy` = 0, `tx_done` = 0 after release.
- **Basic frame:** defaults (`CLKS_PER_BIT` = 16, no parity, 1 stop), send 0xA5. Required: `serial_out` = 0,1,0,1,0,0,1,0,1,1, each held 16 clocks. `tx_done` pulses in cycle 160; `tx_ready` is 1 in cycle 161.
- **Parity:** `PARITY_EN` = 1, send 0x07. Required: parity bit 1 with even parity, 0 with odd. Frame is 176 clocks with 1 stop bit; 192 clocks with `STOP_BITS` = 2.
- **Back-to-back:** hold `tx_valid` = 1 and send 0x00 then 0xFF. Required: second start bit begins 161 clocks after the first start bit, with one high cycle between frames. Both frames are bit-exact.
- **Input isolation:** change `tx_data` to 0x3C mid-frame while pulsing `tx_valid`. Required: transmitted bits still match the originally accepted word; no extra frame is sent.
- **Reset mid-frame:** assert `rst` during data bit 3. Required: `serial_out` = 1 next cycle, no `tx_done`. A subsequent send of 0x81 is transmitted correctly.
